// File: rtl/nd_2to1_arb_pkg.sv
// Shared definitions for the 2-to-1 sequencing arbiter: state encoding,
// default widths/depths and the round-robin tie-break rule.
package nd_2to1_arb_pkg;

   localparam int NS_DATA_SIZE    = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RET  = 2'd2
   } st_e;

   // A lone requester wins outright; on a tie the input not served last wins.
   function automatic logic rr_pick(input logic s0, input logic s1, input logic last);
      return (s0 && s1) ? ~last : s1;
   endfunction

endpackage

// File: rtl/ns_sync_bit.sv
// STAGES-deep single-bit synchronizer with asynchronous active-low clear.
module ns_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/nd_2to1_arb.sv
// Merges two four-phase req/ack message channels onto one output channel,
// one message in flight at a time, round-robin on ties.
module nd_2to1_arb
   import nd_2to1_arb_pkg::*;
#(
   parameter int DSZ         = NS_DATA_SIZE,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CSZ         = 16
) (
   input  logic           i_clk,
   input  logic           reset,
   output logic           ready,
   input  logic           rcv0_req,
   input  logic [DSZ-1:0] rcv0_dat,
   output logic           rcv0_ack,
   input  logic           rcv1_req,
   input  logic [DSZ-1:0] rcv1_dat,
   output logic           rcv1_ack,
   output logic           snd0_req,
   output logic [DSZ-1:0] snd0_dat,
   input  logic           snd0_ack,
   output logic [CSZ-1:0] grant_cnt0,
   output logic [CSZ-1:0] grant_cnt1,
   output logic           last_grant
);

   logic s0, s1, sa;

   // Only the handshake lines cross domains; data is bundled and sampled
   // solely while the synchronized request is high.
   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign s0 = rcv0_req;
         assign s1 = rcv1_req;
         assign sa = snd0_ack;
      end else begin : g_sync
         ns_sync_bit #(.STAGES(SYNC_STAGES)) u_s0 (
            .clk(i_clk), .rst_n(reset), .d_i(rcv0_req), .q_o(s0));
         ns_sync_bit #(.STAGES(SYNC_STAGES)) u_s1 (
            .clk(i_clk), .rst_n(reset), .d_i(rcv1_req), .q_o(s1));
         ns_sync_bit #(.STAGES(SYNC_STAGES)) u_sa (
            .clk(i_clk), .rst_n(reset), .d_i(snd0_ack), .q_o(sa));
      end
   endgenerate

   st_e            state_q;
   logic           sel_q;
   logic           last_q;
   logic           ready_q;
   logic           snd_req_q;
   logic [DSZ-1:0] snd_dat_q;
   logic           ack0_q, ack1_q;
   logic [CSZ-1:0] cnt0_q, cnt1_q;

   logic sel_d;
   logic rsel_req;

   assign sel_d    = rr_pick(s0, s1, last_q);
   assign rsel_req = sel_q ? s1 : s0;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         sel_q     <= 1'b0;
         last_q    <= 1'b1;
         ready_q   <= 1'b0;
         snd_req_q <= 1'b0;
         snd_dat_q <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         ready_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (s0 || s1) begin
                  sel_q     <= sel_d;
                  snd_dat_q <= sel_d ? rcv1_dat : rcv0_dat;
                  snd_req_q <= 1'b1;
                  state_q   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (sa) begin
                  snd_req_q <= 1'b0;
                  last_q    <= sel_q;
                  if (sel_q) begin
                     ack1_q <= 1'b1;
                     cnt1_q <= cnt1_q + CSZ'(1);
                  end else begin
                     ack0_q <= 1'b1;
                     cnt0_q <= cnt0_q + CSZ'(1);
                  end
                  state_q <= ST_RET;
               end
            end
            ST_RET: begin
               // Both the source and the sink must have released before re-arbitrating.
               if (!rsel_req && !sa) begin
                  ack0_q  <= 1'b0;
                  ack1_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ready      = ready_q;
   assign rcv0_ack   = ack0_q;
   assign rcv1_ack   = ack1_q;
   assign snd0_req   = snd_req_q;
   assign snd0_dat   = snd_dat_q;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
   assign last_grant = last_q;

endmodule
